// File: rtl/control_sequencer_if.sv
// Control-sequencer signal bundle: stepping inputs plus the decoded control word.
interface control_sequencer_if;
  logic        step_en;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  // Driver side: supplies enable, instruction and flags; observes the control word.
  modport master (
    output step_en, opcode, flag_c, flag_z,
    input  ctrl, step, halted
  );

  // Sequencer side.
  modport slave (
    input  step_en, opcode, flag_c, flag_z,
    output ctrl, step, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: walks T-states and decodes
// opcode/step/flags into the 16-bit register and bus control word.
module control_sequencer #(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input logic clk,
  input logic rst,
  control_sequencer_if.slave bus
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  logic [2:0]  step_q, step_n;
  logic        halted_q, halted_n;
  logic [15:0] word;

  // Microcode decode: fetch in T0/T1, per-opcode execute from T2 on.
  always_comb begin
    word = '0;
    case (step_q)
      3'd0: word = C_CO | C_MI;
      3'd1: word = C_RO | C_II | C_CE;
      3'd2: begin
        case (bus.opcode)
          4'd1, 4'd2,
          4'd3, 4'd4: word = C_IO | C_MI;
          4'd5:       word = C_IO | C_AI;
          4'd6:       word = C_IO | C_J;
          4'd7:       word = bus.flag_c ? (C_IO | C_J) : 16'h0000;
          4'd8:       word = bus.flag_z ? (C_IO | C_J) : 16'h0000;
          4'd14:      word = C_AO | C_OI;
          4'd15:      word = C_HLT;
          default:    word = '0;
        endcase
      end
      3'd3: begin
        case (bus.opcode)
          4'd1:       word = C_RO | C_AI;
          4'd2, 4'd3: word = C_RO | C_BI;
          4'd4:       word = C_AO | C_RI;
          default:    word = '0;
        endcase
      end
      3'd4: begin
        case (bus.opcode)
          4'd2:    word = C_EO | C_AI | C_FI;
          4'd3:    word = C_EO | C_AI | C_SU | C_FI;
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

  // Step advance: HLT latches halted, empty steps end the instruction early,
  // otherwise count up and wrap at the last T-state.
  always_comb begin
    step_n   = step_q;
    halted_n = halted_q;
    if (bus.step_en && !halted_q) begin
      if (word[15]) begin
        halted_n = 1'b1;
        step_n   = 3'd0;
      end else if (step_q == LAST || (EARLY_END && step_q >= 3'd2 && word == 16'h0000)) begin
        step_n = 3'd0;
      end else begin
        step_n = step_q + 3'd1;
      end
    end
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_n;
      halted_q <= halted_n;
    end
  end

  // Reset forces an idle word; a halted CPU only shows HLT.
  always_comb begin
    if (rst)           bus.ctrl = 16'h0000;
    else if (halted_q) bus.ctrl = C_HLT;
    else               bus.ctrl = word;
  end

  assign bus.step   = step_q;
  assign bus.halted = halted_q;

endmodule
